// File: rtl/hp_bar_pkg.sv
// Shared types and colour constants for the HP-bar damage unit.
package hp_bar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DRAW = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] COLOUR_WHITE = 3'b111;
    localparam logic [2:0] COLOUR_GREEN = 3'b010;
    localparam logic [2:0] COLOUR_BLACK = 3'b000;

endpackage

// File: rtl/hp_bar_pixel_walker.sv
// Column/row cursor over the HP bar: rows inner, columns outer, either x direction.
module hp_bar_pixel_walker
    import hp_bar_pkg::*;
#(
    parameter int X_W = 9,
    parameter int Y_W = 8,
    parameter int BAR_Y = 119,
    parameter int BAR_H = 4,
    parameter logic [X_W-1:0] X_RESET = '0
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           load,
    input  logic [X_W-1:0] x_start,
    input  logic [X_W-1:0] x_end,
    input  logic           dir,
    input  logic           advance,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);

    localparam logic [Y_W-1:0] Y_TOP = Y_W'(BAR_Y);
    localparam logic [Y_W-1:0] Y_BOT = Y_W'(BAR_Y + BAR_H - 1);

    logic [X_W-1:0] x_end_q;
    logic           dir_q;

    // dir_q=1 walks columns upward (refill), 0 walks downward (erase)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x       <= X_RESET;
            y       <= Y_TOP;
            x_end_q <= X_RESET;
            dir_q   <= 1'b0;
        end else if (load) begin
            x       <= x_start;
            y       <= Y_TOP;
            x_end_q <= x_end;
            dir_q   <= dir;
        end else if (advance) begin
            if (y == Y_BOT) begin
                y <= Y_TOP;
                x <= dir_q ? x + X_W'(1) : x - X_W'(1);
            end else begin
                y <= y + Y_W'(1);
            end
        end
    end

    assign last = (x == x_end_q) && (y == Y_BOT);

endmodule

// File: rtl/hp_bar_damage_unit.sv
// HP register plus bar-pixel streamer for one combatant.
// Heal requests are honoured only when HP_BAR_HEAL_EN is defined.
module hp_bar_damage_unit
    import hp_bar_pkg::*;
#(
    parameter int HP_W = 9,
    parameter int HP_MAX = 81,
    parameter int X_W = 9,
    parameter int Y_W = 8,
    parameter int BAR_X_LEFT = 222,
    parameter int BAR_Y = 119,
    parameter int BAR_H = 4,
    parameter logic [2:0] ERASE_COLOUR = COLOUR_WHITE,
    parameter logic [2:0] FILL_COLOUR = COLOUR_GREEN
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [HP_W-1:0] damage,
    input  logic            heal,
    input  logic            restore,
    output logic            ready,
    output logic            pix_valid,
    input  logic            pix_ready,
    output logic [X_W-1:0]  pix_x,
    output logic [Y_W-1:0]  pix_y,
    output logic [2:0]      pix_colour,
    output logic            done,
    output logic [HP_W-1:0] hp,
    output logic            game_over
);

`ifdef HP_BAR_HEAL_EN
    localparam logic HEAL_BUILD = 1'b1;
`else
    localparam logic HEAL_BUILD = 1'b0;
`endif

    localparam logic [HP_W-1:0] HP_FULL     = HP_W'(HP_MAX);
    localparam logic [HP_W:0]   HP_FULL_EXT = (HP_W+1)'(HP_MAX);
    localparam logic [X_W-1:0]  X_LEFT      = X_W'(BAR_X_LEFT);
    localparam logic [X_W-1:0]  X_RESET     = X_W'(BAR_X_LEFT + HP_MAX);

    state_t          state, state_nxt;
    logic [HP_W-1:0] old_hp, damage_q, new_hp;
    logic [HP_W:0]   old_ext, dmg_ext, sum_ext;
    logic            heal_q, heal_mode;
    logic [X_W-1:0]  x_old, x_new, walk_start, walk_end;
    logic            walk_load, walk_last;

    assign heal_mode = heal_q && HEAL_BUILD;

    // Widened by one bit so neither subtraction nor heal overflow can wrap
    always_comb begin
        old_ext = {1'b0, old_hp};
        dmg_ext = {1'b0, damage_q};
        sum_ext = old_ext + dmg_ext;
        if (heal_mode)
            new_hp = (sum_ext > HP_FULL_EXT) ? HP_FULL : sum_ext[HP_W-1:0];
        else
            new_hp = (dmg_ext >= old_ext) ? '0 : old_hp - damage_q;
    end

    always_comb begin
        x_old = X_LEFT + X_W'(old_hp);
        x_new = X_LEFT + X_W'(new_hp);
        if (heal_mode) begin
            walk_start = x_old + X_W'(1);
            walk_end   = x_new;
        end else begin
            walk_start = x_old;
            walk_end   = x_new + X_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            hp        <= HP_FULL;
            game_over <= 1'b0;
            old_hp    <= HP_FULL;
            damage_q  <= '0;
            heal_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        damage_q <= damage;
                        heal_q   <= heal;
                        old_hp   <= hp;
                    end else if (restore) begin
                        hp        <= HP_FULL;
                        game_over <= 1'b0;
                    end
                end
                CALC: begin
                    hp        <= new_hp;
                    game_over <= (new_hp == '0);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        ready      = 1'b0;
        pix_valid  = 1'b0;
        done       = 1'b0;
        walk_load  = 1'b0;
        pix_colour = ERASE_COLOUR;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = CALC;
            end
            CALC: begin
                walk_load = 1'b1;
                state_nxt = (new_hp == old_hp) ? DONE : DRAW;
            end
            DRAW: begin
                pix_valid = 1'b1;
                if (heal_mode) pix_colour = FILL_COLOUR;
                if (pix_ready && walk_last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    hp_bar_pixel_walker #(
        .X_W     (X_W),
        .Y_W     (Y_W),
        .BAR_Y   (BAR_Y),
        .BAR_H   (BAR_H),
        .X_RESET (X_RESET)
    ) u_walker (
        .clock   (clock),
        .reset   (reset),
        .load    (walk_load),
        .x_start (walk_start),
        .x_end   (walk_end),
        .dir     (heal_mode),
        .advance (pix_valid && pix_ready),
        .x       (pix_x),
        .y       (pix_y),
        .last    (walk_last)
    );

endmodule

// File: tb/tb_hp_bar_damage_unit.sv
// Randomised self-checking bench for hp_bar_damage_unit (define HP_BAR_HEAL_EN for the heal build).
module tb_hp_bar_damage_unit;

    localparam int HP_MAX = 81;
    localparam int XL     = 222;
    localparam int BY     = 119;
    localparam int BH     = 4;
`ifdef HP_BAR_HEAL_EN
    localparam bit HEAL_BUILD = 1'b1;
`else
    localparam bit HEAL_BUILD = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [8:0] damage = '0;
    logic       heal = 1'b0;
    logic       restore = 1'b0;
    logic       pix_ready = 1'b1;
    logic       ready, pix_valid, done, game_over;
    logic [8:0] pix_x;
    logic [7:0] pix_y;
    logic [2:0] pix_colour;
    logic [8:0] hp;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int m_hp = HP_MAX;
    int last_xfer = -1;
    logic [19:0] got_q[$];
    logic [19:0] exp_q[$];

    hp_bar_damage_unit dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .damage     (damage),
        .heal       (heal),
        .restore    (restore),
        .ready      (ready),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_colour (pix_colour),
        .done       (done),
        .hp         (hp),
        .game_over  (game_over)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference model: next HP and the ordered list of pixels the bar update should produce
    task automatic model_req(input int dmg, input bit hl);
        int old_hp;
        old_hp = m_hp;
        exp_q.delete();
        if (hl && HEAL_BUILD) begin
            m_hp = (old_hp + dmg > HP_MAX) ? HP_MAX : old_hp + dmg;
            for (int h = old_hp + 1; h <= m_hp; h++)
                for (int r = 0; r < BH; r++)
                    exp_q.push_back({9'(XL + h), 8'(BY + r), 3'b010});
        end else begin
            m_hp = (dmg >= old_hp) ? 0 : old_hp - dmg;
            for (int h = old_hp; h > m_hp; h--)
                for (int r = 0; r < BH; r++)
                    exp_q.push_back({9'(XL + h), 8'(BY + r), 3'b111});
        end
    endtask

    function automatic int list_mismatch();
        if (got_q.size() != exp_q.size()) return -2;
        foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    // Issues one request and collects transfers until done; mode 0 ready high, 1 toggling, 2 random.
    // inj!=0 raises start with that damage while the unit is already busy.
    task automatic run_req(input int dmg, input bit hl, input bit rs, input int mode,
                           input int inj, output int lat);
        bit          stalled;
        logic [19:0] held;
        int          t0;
        got_q.delete();
        lat = -1;
        stalled = 1'b0;
        held = '0;
        last_xfer = -1;
        @(posedge clock); #1;
        start = 1'b1; damage = 9'(dmg); heal = hl; restore = rs; pix_ready = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (done) begin
                lat = cyc - t0;
                break;
            end
            if (stalled) begin
                checks++;
                if (pix_valid !== 1'b1 || {pix_x, pix_y, pix_colour} !== held)
                    $display("FAIL stall_hold: got valid=%b pix=%h, required valid=1 pix=%h",
                             pix_valid, {pix_x, pix_y, pix_colour}, held);
                else passed++;
            end
            stalled = pix_valid && !pix_ready;
            held = {pix_x, pix_y, pix_colour};
            if (pix_valid && pix_ready) begin
                got_q.push_back(held);
                last_xfer = cyc;
            end
            @(posedge clock); #1;
            start = (inj != 0 && i == 1);
            if (start) damage = 9'(inj);
            restore = 1'b0;
            case (mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = ((i + 1) % 2 == 0);
                default: pix_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
        pix_ready = 1'b1;
    endtask

    task automatic do_restore();
        bit saw_valid;
        saw_valid = 1'b0;
        @(posedge clock); #1;
        restore = 1'b1;
        @(posedge clock); #1;
        restore = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            saw_valid |= pix_valid;
        end
        m_hp = HP_MAX;
        checks++;
        if (hp !== 9'd81 || game_over !== 1'b0 || ready !== 1'b1 || saw_valid)
            $display("FAIL restore: got hp=%0d go=%b ready=%b valid_seen=%b, required 81 0 1 0",
                     hp, game_over, ready, saw_valid);
        else passed++;
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++;
        if (ready !== 1'b1 || hp !== 9'd81 || game_over !== 1'b0 || done !== 1'b0 || pix_valid !== 1'b0)
            $display("FAIL reset_flags: got ready=%b hp=%0d go=%b done=%b valid=%b, required 1 81 0 0 0",
                     ready, hp, game_over, done, pix_valid);
        else passed++;
        checks++;
        if (pix_x !== 9'd303 || pix_y !== 8'd119 || pix_colour !== 3'b111)
            $display("FAIL reset_pixel: got (%0d,%0d,%b), required (303,119,111)", pix_x, pix_y, pix_colour);
        else passed++;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (ready !== 1'b1 || hp !== 9'd81)
            $display("FAIL reset_release: got ready=%b hp=%0d, required 1 81", ready, hp);
        else passed++;
    endtask

    task automatic test_damage14();
        int lat, mm;
        model_req(14, 1'b0);
        run_req(14, 1'b0, 1'b0, 0, 0, lat);
        checks++;
        if (hp !== 9'd67 || game_over !== 1'b0)
            $display("FAIL dmg14_hp: got hp=%0d go=%b, required 67 0", hp, game_over);
        else passed++;
        mm = list_mismatch();
        checks++;
        if (mm != -1)
            $display("FAIL dmg14_pixels: got %0d pixels (bad idx %0d), required %0d", got_q.size(), mm, exp_q.size());
        else passed++;
        checks++;
        if (got_q.size() == 0 || got_q[0] !== {9'd303, 8'd119, 3'b111} ||
            got_q[got_q.size()-1] !== {9'd290, 8'd122, 3'b111})
            $display("FAIL dmg14_ends: got %0d pixels, required first (303,119) last (290,122)", got_q.size());
        else passed++;
        checks++;
        if (lat != 58) $display("FAIL dmg14_latency: got %0d, required 58", lat);
        else passed++;
    endtask

    task automatic test_overkill();
        int lat, mm;
        model_req(47, 1'b0);
        run_req(47, 1'b0, 1'b0, 0, 0, lat);
        checks++;
        if (hp !== 9'd20) $display("FAIL to20_hp: got %0d, required 20", hp);
        else passed++;
        model_req(100, 1'b0);
        run_req(100, 1'b0, 1'b0, 0, 0, lat);
        checks++;
        if (hp !== 9'd0 || game_over !== 1'b1)
            $display("FAIL overkill_hp: got hp=%0d go=%b, required 0 1", hp, game_over);
        else passed++;
        mm = list_mismatch();
        checks++;
        if (mm != -1 || got_q.size() != 80 || got_q[0][19:11] !== 9'd242 || got_q[79][19:11] !== 9'd223)
            $display("FAIL overkill_pixels: got %0d pixels (bad idx %0d), required 80 x 242..223", got_q.size(), mm);
        else passed++;
        model_req(5, 1'b0);
        run_req(5, 1'b0, 1'b0, 0, 0, lat);
        checks++;
        if (got_q.size() != 0 || lat != 2 || hp !== 9'd0 || game_over !== 1'b1)
            $display("FAIL dead_hit: got pixels=%0d lat=%0d hp=%0d go=%b, required 0 2 0 1",
                     got_q.size(), lat, hp, game_over);
        else passed++;
    endtask

    task automatic test_restore();
        int lat;
        do_restore();
        model_req(10, 1'b0);
        run_req(10, 1'b0, 1'b1, 0, 0, lat);
        checks++;
        if (hp !== 9'd71 || got_q.size() != 40)
            $display("FAIL start_beats_restore: got hp=%0d pixels=%0d, required 71 40", hp, got_q.size());
        else passed++;
    endtask

    task automatic test_zero_damage();
        int lat;
        model_req(0, 1'b0);
        run_req(0, 1'b0, 1'b0, 0, 0, lat);
        checks++;
        if (lat != 2 || got_q.size() != 0 || hp !== 9'(m_hp))
            $display("FAIL zero_damage: got lat=%0d pixels=%0d hp=%0d, required 2 0 %0d", lat, got_q.size(), hp, m_hp);
        else passed++;
    endtask

    task automatic test_backpressure();
        int lat, mm;
        model_req(3, 1'b0);
        run_req(3, 1'b0, 1'b0, 1, 0, lat);
        mm = list_mismatch();
        checks++;
        if (mm != -1 || got_q.size() != 12)
            $display("FAIL bp_pixels: got %0d pixels (bad idx %0d), required 12", got_q.size(), mm);
        else passed++;
        checks++;
        if (lat < 0 || last_xfer + 1 != cyc)
            $display("FAIL bp_done: got done cycle %0d, required %0d", (lat < 0) ? -1 : cyc, last_xfer + 1);
        else passed++;
    endtask

    task automatic test_busy_start();
        int lat, mm;
        bit moved;
        model_req(4, 1'b0);
        run_req(4, 1'b0, 1'b0, 0, 50, lat);
        mm = list_mismatch();
        checks++;
        if (mm != -1 || hp !== 9'(m_hp))
            $display("FAIL busy_start: got pixels=%0d hp=%0d, required %0d %0d", got_q.size(), hp, exp_q.size(), m_hp);
        else passed++;
        moved = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (ready !== 1'b1 || pix_valid !== 1'b0 || hp !== 9'(m_hp)) moved = 1'b1;
        end
        checks++;
        if (moved) $display("FAIL busy_idle: got activity after done, required idle with hp=%0d", m_hp);
        else passed++;
    endtask

    task automatic test_reset_mid_draw();
        bit saw_done, saw_valid;
        @(posedge clock); #1;
        start = 1'b1; damage = 9'd30; pix_ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        checks++;
        if (pix_valid !== 1'b1) $display("FAIL mid_draw_active: got valid=%b, required 1", pix_valid);
        else passed++;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (pix_valid !== 1'b0 || hp !== 9'd81 || ready !== 1'b1 || done !== 1'b0 || pix_x !== 9'd303)
            $display("FAIL mid_draw_reset: got valid=%b hp=%0d ready=%b done=%b x=%0d, required 0 81 1 0 303",
                     pix_valid, hp, ready, done, pix_x);
        else passed++;
        @(posedge clock); #1;
        reset = 1'b1;
        saw_done = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            saw_done |= done;
            saw_valid |= pix_valid;
        end
        m_hp = HP_MAX;
        checks++;
        if (saw_done || saw_valid)
            $display("FAIL mid_draw_after: got done_seen=%b valid_seen=%b, required 0 0", saw_done, saw_valid);
        else passed++;
    endtask

    task automatic test_heal();
        int lat, mm;
        do_restore();
        model_req(14, 1'b0);
        run_req(14, 1'b0, 1'b0, 0, 0, lat);
        model_req(20, 1'b1);
        run_req(20, 1'b1, 1'b0, 0, 0, lat);
        mm = list_mismatch();
        checks++;
        if (mm != -1 || hp !== 9'(m_hp))
            $display("FAIL heal_pixels: got %0d pixels (bad idx %0d) hp=%0d, required %0d hp=%0d",
                     got_q.size(), mm, hp, exp_q.size(), m_hp);
        else passed++;
`ifdef HP_BAR_HEAL_EN
        checks++;
        if (hp !== 9'd81 || got_q.size() != 56 || got_q[0] !== {9'd290, 8'd119, 3'b010} ||
            got_q[55] !== {9'd303, 8'd122, 3'b010})
            $display("FAIL heal_ends: got hp=%0d pixels=%0d, required 81 56 from (290,119) to (303,122) green",
                     hp, got_q.size());
        else passed++;
`else
        checks++;
        if (hp !== 9'd47 || got_q.size() != 80 || got_q[0] !== {9'd289, 8'd119, 3'b111})
            $display("FAIL heal_ignored: got hp=%0d pixels=%0d, required 47 80 from (289,119) white",
                     hp, got_q.size());
        else passed++;
`endif
    endtask

    task automatic test_random();
        int lat, mm, dmg, mode;
        bit hl, rs;
        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 6) == 0) begin
                do_restore();
                continue;
            end
            dmg  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 300) : $urandom_range(0, 25);
            hl   = $urandom_range(0, 1) == 1;
            rs   = $urandom_range(0, 4) == 0;
            mode = $urandom_range(0, 2);
            model_req(dmg, hl);
            run_req(dmg, hl, rs, mode, 0, lat);
            checks++;
            if (hp !== 9'(m_hp) || game_over !== (m_hp == 0))
                $display("FAIL rand%0d_hp: got hp=%0d go=%b, required %0d %b", n, hp, game_over, m_hp, m_hp == 0);
            else passed++;
            mm = list_mismatch();
            checks++;
            if (mm != -1)
                $display("FAIL rand%0d_pixels: got %0d (bad idx %0d), required %0d", n, got_q.size(), mm, exp_q.size());
            else passed++;
            checks++;
            if (lat < 0 || (mode == 0 && lat != 2 + exp_q.size()))
                $display("FAIL rand%0d_latency: got %0d, required %0d", n, lat, 2 + exp_q.size());
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_damage14();
        test_overkill();
        test_restore();
        test_zero_damage();
        test_backpressure();
        test_busy_start();
        test_reset_mid_draw();
        test_heal();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
